// File: rtl/maxpool_c6.sv
// 2x2 stride-2 max pooling over a raster-order multichannel pixel stream.
// Optional macro MAXPOOL_C6_RELU_EN clamps negative input channels to zero before pooling.
module maxpool_c6 #(
  parameter int N       = 16,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 input_vld,
  input  logic [CHANNEL*N-1:0] input_din,
  output logic [CHANNEL*N-1:0] pool_dout,
  output logic                 pool_dout_vld,
  output logic                 pool_dout_end
);

  localparam int W    = CHANNEL * N;
  localparam int CW   = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam int HALF = SIZE / 2;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  function automatic logic [W-1:0] vmax(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < CHANNEL; c++) begin
      r[c*N +: N] = ($signed(a[c*N +: N]) > $signed(b[c*N +: N])) ? a[c*N +: N] : b[c*N +: N];
    end
    return r;
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [W-1:0]  h_q, h_d;
  logic [W-1:0]  lb_q [HALF];
  logic [W-1:0]  dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          end_q, end_d;

  logic [W-1:0]  x;
  logic [LW-1:0] lb_idx;
  logic [W-1:0]  lb_rd;
  logic          lb_we;
  logic [W-1:0]  lb_wdata;

  always_comb begin
    x = input_din;
`ifdef MAXPOOL_C6_RELU_EN
    for (int unsigned c = 0; c < CHANNEL; c++) begin
      if (input_din[c*N + N - 1]) x[c*N +: N] = '0;
    end
`endif
  end

  // Even columns pair with the following odd column, so col/2 addresses the line buffer.
  assign lb_idx = LW'(col_q >> 1);
  assign lb_rd  = lb_q[lb_idx];

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    h_d      = h_q;
    lb_we    = 1'b0;
    lb_wdata = vmax(h_q, x);
    dout_d   = dout_q;
    vld_d    = 1'b0;
    end_d    = 1'b0;
    if (input_vld) begin
      col_d = (col_q == LAST) ? '0 : col_q + CW'(1);
      if (col_q == LAST) row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
      unique case ({row_q[0], col_q[0]})
        2'b00: h_d = x;
        2'b01: lb_we = 1'b1;
        2'b10: h_d = vmax(lb_rd, x);
        2'b11: begin
          dout_d = vmax(h_q, x);
          vld_d  = 1'b1;
          end_d  = (row_q == LAST) && (col_q == LAST);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      h_q    <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      end_q  <= 1'b0;
      for (int unsigned i = 0; i < HALF; i++) lb_q[i] <= '0;
    end else if (ce) begin
      col_q  <= col_d;
      row_q  <= row_d;
      h_q    <= h_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      end_q  <= end_d;
      if (lb_we) lb_q[lb_idx] <= lb_wdata;
    end
  end

  assign pool_dout     = dout_q;
  assign pool_dout_vld = vld_q;
  assign pool_dout_end = end_q;

endmodule

// File: tb/tb_maxpool_c6.sv
// Scoreboard bench for maxpool_c6 (CHANNEL=3, SIZE=4) against a window-max reference model.
module tb_maxpool_c6;
  localparam int N    = 16;
  localparam int CH   = 3;
  localparam int SZ   = 4;
  localparam int W    = CH * N;
  localparam int NPIX = SZ * SZ;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ce;
  logic         input_vld;
  logic [W-1:0] input_din;
  logic [W-1:0] pool_dout;
  logic         pool_dout_vld;
  logic         pool_dout_end;

  maxpool_c6 #(.N(N), .CHANNEL(CH), .SIZE(SZ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .input_vld    (input_vld),
    .input_din    (input_din),
    .pool_dout    (pool_dout),
    .pool_dout_vld(pool_dout_vld),
    .pool_dout_end(pool_dout_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] frame [SZ][SZ];
  int           k = 0;
  logic         drv_out = 1'b0;
  logic         ce_edge = 1'b0;
  logic         exp_fire;
  logic [W-1:0] exp_dout = '0;
  logic         exp_end = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pk(input int a, input int b, input int c);
    logic [W-1:0] p;
    p[0   +: N] = N'(a);
    p[N   +: N] = N'(b);
    p[2*N +: N] = N'(c);
    return p;
  endfunction

  function automatic logic [W-1:0] relu(input logic [W-1:0] p);
    logic [W-1:0] r;
    r = p;
`ifdef MAXPOOL_C6_RELU_EN
    for (int c = 0; c < CH; c++) begin
      if ($signed(p[c*N +: N]) < 0) r[c*N +: N] = '0;
    end
`endif
    return r;
  endfunction

  // Maximum over the 2x2 window whose bottom-right pixel is (r,c).
  function automatic logic [W-1:0] window_max(input int r, input int c);
    logic [W-1:0]        res;
    logic signed [N-1:0] best;
    logic signed [N-1:0] v;
    res = '0;
    for (int ch = 0; ch < CH; ch++) begin
      best = frame[r][c][ch*N +: N];
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++) begin
          v = frame[r-dr][c-dc][ch*N +: N];
          if (v > best) best = v;
        end
      res[ch*N +: N] = best;
    end
    return res;
  endfunction

  always @(posedge clk) ce_edge <= ce;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_fire <= 1'b0;
    else if (ce) exp_fire <= input_vld && drv_out;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_dout = '0;
      exp_end  = 1'b0;
      chk("reset_dout", 64'(pool_dout), 64'(0));
      chk("reset_vld", 64'(pool_dout_vld), 64'(0));
      chk("reset_end", 64'(pool_dout_end), 64'(0));
    end else begin
      if (ce_edge && exp_fire) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: got output with no expectation at %0t", $time);
        end else begin
          e        = sb.pop_front();
          exp_dout = e.d;
          exp_end  = e.e;
        end
      end else if (ce_edge) begin
        exp_end = 1'b0;
      end
      chk("vld", 64'(pool_dout_vld), 64'(exp_fire));
      chk("end", 64'(pool_dout_end), 64'(exp_end));
      chk("dout", 64'(pool_dout), 64'(exp_dout));
    end
  end

  // Entered and left at posedge+1.
  task automatic drive_pixel(input logic [W-1:0] px);
    int r;
    int c;
    exp_t e;
    r = k / SZ;
    c = k % SZ;
    ce        = 1'b1;
    input_vld = 1'b1;
    input_din = px;
    drv_out   = (r % 2 == 1) && (c % 2 == 1);
    @(posedge clk);
    frame[r][c] = relu(px);
    if (drv_out) begin
      e.d = window_max(r, c);
      e.e = (k == NPIX - 1);
      sb.push_back(e);
    end
    k = (k + 1) % NPIX;
    #1;
    input_vld = 1'b0;
    drv_out   = 1'b0;
  endtask

  task automatic idle(input int n, input logic ce_val);
    repeat (n) begin
      ce        = ce_val;
      input_vld = ce_val ? 1'b0 : 1'($urandom_range(0, 1));
      input_din = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    ce        = 1'b1;
    input_vld = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k     = 0;
  endtask

  function automatic logic [W-1:0] mk(input int mode, input int i);
    case (mode)
      0:       return pk(i, -i, 100 - i);
      1:       return pk(-5, -5, -5);
      default: return pk($urandom_range(0, 20) - 10, $urandom_range(0, 65535), $urandom_range(0, 6) - 3);
    endcase
  endfunction

  // mode: 0 ramp, 1 constant -5, 2 random; toggle inserts one idle cycle per pixel;
  // ce_drop holds ce low 3 cycles after each output pixel; rnd adds random gaps and stalls.
  task automatic run_frame(input int mode, input bit toggle, input bit ce_drop, input bit rnd);
    bit outpix;
    for (int i = 1; i <= NPIX; i++) begin
      outpix = ((k / SZ) % 2 == 1) && ((k % SZ) % 2 == 1);
      drive_pixel(mk(mode, i));
      if (toggle) idle(1, 1'b1);
      if (ce_drop && outpix) idle(3, 1'b0);
      if (rnd) begin
        idle($urandom_range(0, 2), 1'b1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b0);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ce        = 1'b0;
    input_vld = 1'b0;
    input_din = '0;
    #1;
    do_reset(3);

    run_frame(0, 1'b0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b1, 1'b0);

    for (int i = 1; i <= 7; i++) drive_pixel(mk(0, i));
    idle(1, 1'b1);
    do_reset(2);
    run_frame(0, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 6; f++) run_frame(2, 1'b0, 1'b0, 1'b1);
    run_frame(1, 1'b1, 1'b1, 1'b0);

    idle(4, 1'b1);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maxpool_c6.md
MAXPOOL_C6 -- requirements
Module: maxpool_c6

Interface
REQ-001 SHALL have parameter N, default 16: bit width of one signed two's-complement channel sample.
REQ-002 SHALL have parameter CHANNEL, default 3: number of channels per pixel.
REQ-003 SHALL have parameter SIZE, default 6: input frame width and height in pixels, even and at least 2; output frame is SIZE/2 x SIZE/2.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port ce  input  1: clock enable; while low, every register holds its value.
REQ-007 SHALL have port input_vld  input  1: input_din carries a valid pixel this cycle.
REQ-008 SHALL have port input_din  input  CHANNEL*N: one pixel, channel c at bits [c*N +: N].
REQ-009 SHALL have port pool_dout  output  CHANNEL*N: pooled pixel, same channel packing as input_din.
REQ-010 SHALL have port pool_dout_vld  output  1: pool_dout is valid this cycle.
REQ-011 SHALL have port pool_dout_end  output  1: pool_dout is the last pixel of the output frame.

Function
REQ-012 SHALL accept a pixel only in cycles with ce=1 and input_vld=1, in raster order (row-major); gaps of any length between accepted pixels SHALL be tolerated.
REQ-013 SHALL track the position of the accepted pixel with column counter col (0..SIZE-1) and row counter row (0..SIZE-1); col wraps to 0 after SIZE-1 and increments row; row wraps to 0 after SIZE-1 with no idle cycle, so the next accepted pixel starts a new frame.
REQ-014 SHALL compute the per-channel maximum as a signed comparison, independently per channel; equal values yield that value.
REQ-015 On even row and even col, SHALL store x into hold register h.
REQ-016 On even row and odd col, SHALL write max(h,x) into line buffer entry col/2; the line buffer holds SIZE/2 entries of CHANNEL*N bits.
REQ-017 On odd row and even col, SHALL store max(linebuf[col/2],x) into h.
REQ-018 On odd row and odd col, SHALL register max(h,x) into pool_dout and assert pool_dout_vld in the following cycle (latency 1 cycle from the accepting edge).
REQ-019 SHALL assert pool_dout_vld for exactly one ce-enabled cycle per output pixel; it SHALL deassert on the next ce=1 cycle unless a new output is produced then.
REQ-020 SHALL assert pool_dout_end together with pool_dout_vld only for the output produced at row=SIZE-1, col=SIZE-1.
REQ-021 SHALL hold pool_dout at its last value while pool_dout_vld is low.
REQ-022 With ce=0, SHALL hold pool_dout_vld and pool_dout_end at their current levels, ignore input_vld, and not advance any counter.

Reset
REQ-023 While rst_n=0, SHALL clear pool_dout, pool_dout_vld, pool_dout_end, col, row, h and all line buffer entries to 0, regardless of clk.
REQ-024 SHALL discard a partial frame on reset mid-frame; the first pixel accepted after rst_n deasserts SHALL be treated as row 0, col 0.

Configuration
REQ-025 With macro MAXPOOL_C6_RELU_EN defined, SHALL clamp each negative input channel to 0 before any comparison, so pool_dout is never negative.
REQ-026 With MAXPOOL_C6_RELU_EN undefined, SHALL pass inputs unmodified, so negative maxima appear on pool_dout.

Verification (CHANNEL=1, SIZE=4 unless stated)
REQ-027 Feed 1..16 raster, input_vld held high -> outputs 6, 8, 14, 16 (each 1 cycle after pixels 6, 8, 14, 16 are accepted); pool_dout_end high only with 16.
REQ-028 Same frame with input_vld toggling 1,0,1,0 -> identical output values; exactly 4 single-cycle vld pulses.
REQ-029 Frame of all -5 -> without MAXPOOL_C6_RELU_EN, four outputs of -5 (0xFFFB); with the macro, four outputs of 0.
REQ-030 Drop ce for 3 cycles while pool_dout_vld is high -> vld and data held for those cycles; no pixel lost; next output still correct.
REQ-031 Assert rst_n=0 after 7 pixels, then feed a full frame 1..16 -> all outputs zero during reset; outputs 6, 8, 14, 16 with end on 16.
REQ-032 CHANNEL=3, two back-to-back frames with channel values (k, -k, 100-k) for pixel k=1..16 -> per frame (6,-1,99), (8,-3,97), (14,-9,91), (16,-11,89); end asserted on each 4th output.
